// File: rtl/uart_tx_shift_if.sv
// Transmit-side handshake and serial line of the UART transmitter.
// The master supplies words; the slave (the transmitter) drives the line and status.
interface uart_tx_shift_if #(
  parameter int unsigned width = 7
) ();
  logic [width:0] data_in;
  logic           tx_start;
  logic           ready;
  logic           tx;
  logic           done;

  modport master (
    output data_in,
    output tx_start,
    input  ready,
    input  tx,
    input  done
  );

  modport slave (
    input  data_in,
    input  tx_start,
    output ready,
    output tx,
    output done
  );
endinterface

// File: rtl/uart_tx_shift.sv
// Parallel-in, serial-out UART transmitter: start, width+1 data bits LSB first,
// optional parity, one stop bit, each held for CLK_DIV clocks.
module uart_tx_shift #(
  parameter int unsigned width      = 7,
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic           clk,
  input logic           rst,
  uart_tx_shift_if.slave bus
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned BitW = (width > 0) ? $clog2(width + 1) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(width);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [width:0]  shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;

  logic baud_end;
  assign baud_end = (baud_q == '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.tx_start) begin
          shift_d = bus.data_in;
          par_d   = (^bus.data_in) ^ PARITY_ODD[0];
          baud_d  = CntReload;
          bit_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = CntReload;
          state_d = StData;
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d  = CntReload;
          shift_d = shift_q >> 1;
          if (bit_q == BitLast) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      StParity: begin
        if (baud_end) begin
          baud_d  = CntReload;
          state_d = StStop;
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d  = CntReload;
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line and ready are decoded from the next state so they stay registered yet
  // change on the same edge as the state they describe.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = (state_d == StIdle);
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_uart_tx_shift.sv
// Directed bench: three transmitters (no parity, even, odd) with CLK_DIV=4,
// frames checked bit by bit against hand-written expected line patterns.
module tb_uart_tx_shift;

  localparam int Div = 4;

  logic clk;
  logic rst;

  uart_tx_shift_if #(.width(7)) if0 ();
  uart_tx_shift_if #(.width(7)) ife ();
  uart_tx_shift_if #(.width(7)) ifo ();

  uart_tx_shift #(.width(7), .CLK_DIV(Div), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  uart_tx_shift #(.width(7), .CLK_DIV(Div), .PARITY_EN(1), .PARITY_ODD(0)) dut_e (
    .clk(clk), .rst(rst), .bus(ife)
  );
  uart_tx_shift #(.width(7), .CLK_DIV(Div), .PARITY_EN(1), .PARITY_ODD(1)) dut_o (
    .clk(clk), .rst(rst), .bus(ifo)
  );

  logic [2:0] tx_v, ready_v, done_v;
  assign tx_v    = {ifo.tx, ife.tx, if0.tx};
  assign ready_v = {ifo.ready, ife.ready, if0.ready};
  assign done_v  = {ifo.done, ife.done, if0.done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // frame bit 0 is sent first: {pad, stop, [parity], data msb..lsb, start}
  typedef struct {
    string       name;
    int          sel;
    logic [7:0]  data;
    logic [10:0] frame;
    int          nbits;
    int          mode;   // 0 plain, 1 busy tx_start poke, 2 data_in scrambled
  } vec_t;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int sel, input logic start, input logic [7:0] data);
    case (sel)
      0: begin if0.tx_start = start; if0.data_in = data; end
      1: begin ife.tx_start = start; ife.data_in = data; end
      default: begin ifo.tx_start = start; ifo.data_in = data; end
    endcase
  endtask

  // Entered 1 time unit after the accepting edge; leaves 1 unit after the edge
  // that ends the stop bit, having checked the done pulse there.
  task automatic check_frame(input string name, input int sel, input logic [10:0] frame,
                             input int nbits, input int mode);
    int cyc;
    cyc = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < Div; k++) begin
        chk($sformatf("%s tx bit%0d cyc%0d", name, b, k), tx_v[sel], frame[b]);
        chk($sformatf("%s ready busy cyc%0d", name, cyc), ready_v[sel], 1'b0);
        chk($sformatf("%s done early cyc%0d", name, cyc), done_v[sel], 1'b0);
        if (mode == 1) set_in(sel, (cyc == 10), 8'h3C);
        if (mode == 2) set_in(sel, 1'b0, 8'($urandom));
        cyc++;
        tick();
      end
    end
    chk({name, " done pulse"}, done_v[sel], 1'b1);
    chk({name, " ready at end"}, ready_v[sel], 1'b1);
    chk({name, " tx idle at end"}, tx_v[sel], 1'b1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"a5_plain",  0, 8'hA5, 11'b1_1_10100101_0, 10, 0};
    vecs[1] = '{"a5_even",   1, 8'hA5, 11'b1_0_10100101_0, 11, 0};
    vecs[2] = '{"a5_odd",    2, 8'hA5, 11'b1_1_10100101_0, 11, 0};
    vecs[3] = '{"a5_busy",   0, 8'hA5, 11'b1_1_10100101_0, 10, 1};
    vecs[4] = '{"5a_stable", 0, 8'h5A, 11'b1_1_01011010_0, 10, 2};

    rst = 1'b0;
    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 8'h00);

    // asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("reset tx", if0.tx, 1'b1);
    chk("reset ready", if0.ready, 1'b1);
    chk("reset done", if0.done, 1'b0);
    chk("reset tx parity dut", ife.tx, 1'b1);
    tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      set_in(vecs[i].sel, 1'b1, vecs[i].data);
      tick();
      set_in(vecs[i].sel, 1'b0, vecs[i].data);
      check_frame(vecs[i].name, vecs[i].sel, vecs[i].frame, vecs[i].nbits, vecs[i].mode);
      set_in(vecs[i].sel, 1'b0, 8'h00);
      tick();
      chk({vecs[i].name, " done single"}, done_v[vecs[i].sel], 1'b0);
      chk({vecs[i].name, " tx idle after"}, tx_v[vecs[i].sel], 1'b1);
      tick();
    end

    // back-to-back with tx_start held high
    set_in(0, 1'b1, 8'h00);
    tick();
    set_in(0, 1'b1, 8'hFF);
    check_frame("b2b_00", 0, 11'b1_1_00000000_0, 10, 0);
    tick();
    set_in(0, 1'b0, 8'hFF);
    chk("b2b second start bit", if0.tx, 1'b0);
    chk("b2b second done clear", if0.done, 1'b0);
    check_frame("b2b_ff", 0, 11'b1_1_11111111_0, 10, 0);
    tick();
    chk("b2b stays idle", if0.tx, 1'b1);
    chk("b2b no third frame done", if0.done, 1'b0);
    repeat (Div) tick();
    chk("b2b no third frame tx", if0.tx, 1'b1);

    // reset in the middle of the data bits of 0xFF
    set_in(0, 1'b1, 8'hFF);
    tick();
    set_in(0, 1'b0, 8'h00);
    repeat (12) tick();
    chk("mid data before reset", if0.tx, 1'b1);
    chk("mid ready before reset", if0.ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid reset ready async", if0.ready, 1'b1);
    chk("mid reset done async", if0.done, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("in reset tx cyc%0d", c), if0.tx, 1'b1);
      chk($sformatf("in reset done cyc%0d", c), if0.done, 1'b0);
    end
    rst = 1'b0;
    for (int c = 0; c < 2 * Div * 10; c++) begin
      tick();
      chk($sformatf("post reset no done cyc%0d", c), if0.done, 1'b0);
      chk($sformatf("post reset tx idle cyc%0d", c), if0.tx, 1'b1);
    end
    set_in(0, 1'b1, 8'h81);
    tick();
    set_in(0, 1'b0, 8'h00);
    check_frame("after_reset_81", 0, 11'b1_1_10000001_0, 10, 0);
    tick();
    chk("after_reset done single", if0.done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
